// File: rtl/msxseq_pkg.sv
// Shared encodings for the MSX bus sequencer: FSM states, MODE codes, MD bit map, OE masks.
// The optional READY timeout is enabled by defining MSXSEQ_TIMEOUT_EN.
package msxseq_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADDR = 3'd1,
    S_CMD  = 3'd2,
    S_CAPT = 3'd3,
    S_REL  = 3'd4,
    S_DONE = 3'd5
  } state_t;

  localparam logic [1:0] MODE_ADDR = 2'd0;
  localparam logic [1:0] MODE_CMD  = 2'd1;
  localparam logic [1:0] MODE_REL  = 2'd2;

  localparam int MD_IO      = 15;
  localparam int MD_RW      = 14;
  localparam int MD_SLT     = 13;
  localparam int MD_ST_HI   = 12;
  localparam int MD_ST_LO   = 8;
  localparam int MD_DATA_HI = 7;

  localparam logic [2:0] OE_NONE = 3'b000;
  localparam logic [2:0] OE_ALL  = 3'b111;
  localparam logic [2:0] OE_WR   = 3'b101;
  localparam logic [2:0] OE_RD   = 3'b100;

  function automatic logic [15:0] cmd_word(input logic io, input logic rw,
                                           input logic slt, input logic [7:0] wdata);
    logic [15:0] w;
    w = '0;
    w[MD_IO]          = io;
    w[MD_RW]          = rw;
    w[MD_SLT]         = slt;
    w[MD_DATA_HI:0]   = wdata;
    return w;
  endfunction

endpackage

// File: rtl/msxseq_rr2.sv
// Two-way round-robin picker: a lone request wins outright; a tie goes to the
// requester that was not served last.
module msxseq_rr2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       grant,
  output logic       gnt_idx
);

  assign grant   = |req;
  assign gnt_idx = (&req) ? ~last : req[1];

endmodule

// File: rtl/msxbus_sequencer.sv
// Two-requester arbiter/sequencer driving the MSX bus master MODE/MD handshake.
// Define MSXSEQ_TIMEOUT_EN to bound the CMD/REL waits on READY (adds TIMEOUT_CYC and ERR).
module msxbus_sequencer
  import msxseq_pkg::*;
#(
  parameter int ADDR_SETUP  = 2
`ifdef MSXSEQ_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = 255
`endif
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req0,
  input  logic        req1,
  input  logic [15:0] addr0,
  input  logic [15:0] addr1,
  input  logic [7:0]  wdata0,
  input  logic [7:0]  wdata1,
  input  logic        rw0,
  input  logic        rw1,
  input  logic        io0,
  input  logic        io1,
  input  logic        slt0,
  input  logic        slt1,
  output logic        ack0,
  output logic        ack1,
  output logic [7:0]  rdata,
  output logic [4:0]  status,
  output logic        err,
  output logic [1:0]  mode,
  output logic [15:0] md_out,
  output logic [2:0]  md_oe,
  input  logic [15:0] md_in,
  input  logic        ready,
  output logic [2:0]  state_dbg
);

  localparam int SET_W = (ADDR_SETUP > 1) ? $clog2(ADDR_SETUP) : 1;
  localparam logic [SET_W-1:0] SET_LAST = SET_W'(ADDR_SETUP - 1);

  state_t          state;
  logic            gnt_valid, gnt_idx, rr_last;
  logic            cur_idx, cur_rw, cur_io, cur_slt;
  logic [15:0]     cur_addr, sel_addr;
  logic [7:0]      cur_wdata, sel_wdata;
  logic            sel_rw, sel_io, sel_slt;
  logic [SET_W-1:0] setup_cnt;
  logic            unused_md_hi;

`ifdef MSXSEQ_TIMEOUT_EN
  localparam int WAIT_W = (TIMEOUT_CYC > 255) ? $clog2(TIMEOUT_CYC + 1) : 8;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYC - 1);
  logic [WAIT_W-1:0] wait_cnt;
  logic              timed_out;
  logic              err_q;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  // MD[15:13] are outputs only from this block's point of view.
  assign unused_md_hi = ^md_in[15:13];
  assign state_dbg    = state;

  msxseq_rr2 u_rr2 (
    .req     ({req1, req0}),
    .last    (rr_last),
    .grant   (gnt_valid),
    .gnt_idx (gnt_idx)
  );

  assign sel_addr  = gnt_idx ? addr1  : addr0;
  assign sel_wdata = gnt_idx ? wdata1 : wdata0;
  assign sel_rw    = gnt_idx ? rw1    : rw0;
  assign sel_io    = gnt_idx ? io1    : io0;
  assign sel_slt   = gnt_idx ? slt1   : slt0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      mode      <= MODE_REL;
      md_oe     <= OE_NONE;
      md_out    <= '0;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      rdata     <= '0;
      status    <= '0;
      rr_last   <= 1'b1;
      cur_idx   <= 1'b0;
      cur_rw    <= 1'b0;
      cur_io    <= 1'b0;
      cur_slt   <= 1'b0;
      cur_addr  <= '0;
      cur_wdata <= '0;
      setup_cnt <= '0;
`ifdef MSXSEQ_TIMEOUT_EN
      wait_cnt  <= '0;
      timed_out <= 1'b0;
      err_q     <= 1'b0;
`endif
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      case (state)
        S_IDLE: begin
          if (gnt_valid) begin
            cur_idx   <= gnt_idx;
            rr_last   <= gnt_idx;
            cur_addr  <= sel_addr;
            cur_wdata <= sel_wdata;
            cur_rw    <= sel_rw;
            cur_io    <= sel_io;
            cur_slt   <= sel_slt;
            mode      <= MODE_ADDR;
            md_oe     <= OE_ALL;
            md_out    <= sel_addr;
            setup_cnt <= '0;
`ifdef MSXSEQ_TIMEOUT_EN
            timed_out <= 1'b0;
`endif
            state     <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (setup_cnt == SET_LAST) begin
            mode   <= MODE_CMD;
            md_out <= cmd_word(cur_io, cur_rw, cur_slt, cur_wdata);
            md_oe  <= cur_rw ? OE_WR : OE_RD;
`ifdef MSXSEQ_TIMEOUT_EN
            wait_cnt <= '0;
`endif
            state  <= S_CMD;
          end else begin
            setup_cnt <= setup_cnt + 1'b1;
          end
        end
        S_CMD: begin
          if (!ready) begin
            md_oe <= OE_NONE;
            state <= S_CAPT;
          end
`ifdef MSXSEQ_TIMEOUT_EN
          // No response from the master: release the bus and finish with ERR.
          else if (wait_cnt == WAIT_LAST) begin
            mode      <= MODE_REL;
            md_oe     <= OE_NONE;
            timed_out <= 1'b1;
            state     <= S_REL;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end
        S_CAPT: begin
          if (!cur_rw) rdata <= md_in[MD_DATA_HI:0];
          status <= md_in[MD_ST_HI:MD_ST_LO];
          mode   <= MODE_REL;
          md_oe  <= OE_NONE;
`ifdef MSXSEQ_TIMEOUT_EN
          wait_cnt <= '0;
`endif
          state  <= S_REL;
        end
        S_REL: begin
`ifdef MSXSEQ_TIMEOUT_EN
          if (ready || timed_out || (wait_cnt == WAIT_LAST)) begin
            ack0  <= ~cur_idx;
            ack1  <= cur_idx;
            err_q <= timed_out | ~ready;
            state <= S_DONE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`else
          if (ready) begin
            ack0  <= ~cur_idx;
            ack1  <= cur_idx;
            state <= S_DONE;
          end
`endif
        end
        S_DONE: begin
          mode  <= MODE_REL;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_msxbus_sequencer.sv
// Directed bench for msxbus_sequencer with a small behavioural MSX bus master model.
// Define MSXSEQ_TIMEOUT_EN to also exercise the READY timeout path.
module tb_msxbus_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req0, req1;
  logic [15:0] addr0, addr1;
  logic [7:0]  wdata0, wdata1;
  logic        rw0, rw1, io0, io1, slt0, slt1;
  logic        ack0, ack1;
  logic [7:0]  rdata;
  logic [4:0]  status;
  logic        err;
  logic [1:0]  mode;
  logic [15:0] md_out;
  logic [2:0]  md_oe;
  logic [15:0] md_in;
  logic        ready;
  logic [2:0]  state_dbg;

  int checks = 0;
  int errors = 0;

  // master model knobs
  int         m_cmd_dly = 1;
  int         m_rel_dly = 1;
  logic       m_early   = 1'b0;
  logic [7:0] m_rdata   = 8'h00;
  logic [4:0] m_status  = 5'b00000;
  int         m_cnt     = 0;
  logic       m_ph      = 1'b0;

  always #5 clk = ~clk;

  msxbus_sequencer #(
    .ADDR_SETUP (2)
`ifdef MSXSEQ_TIMEOUT_EN
    , .TIMEOUT_CYC (16)
`endif
  ) dut (
    .clk (clk), .reset_n (reset_n),
    .req0 (req0), .req1 (req1),
    .addr0 (addr0), .addr1 (addr1),
    .wdata0 (wdata0), .wdata1 (wdata1),
    .rw0 (rw0), .rw1 (rw1), .io0 (io0), .io1 (io1), .slt0 (slt0), .slt1 (slt1),
    .ack0 (ack0), .ack1 (ack1), .rdata (rdata), .status (status), .err (err),
    .mode (mode), .md_out (md_out), .md_oe (md_oe), .md_in (md_in), .ready (ready),
    .state_dbg (state_dbg)
  );

  // Master: pulls READY low m_cmd_dly cycles into the command phase (or already
  // in the address phase when m_early), releases it m_rel_dly cycles into release.
  always @(negedge clk) begin
    if (!reset_n) begin
      ready = 1'b1; md_in = 16'h0000; m_ph = 1'b0; m_cnt = 0;
    end else if (!m_ph) begin
      if ((mode == 2'd1) || (m_early && mode == 2'd0)) begin
        if (m_cnt >= m_cmd_dly) begin
          ready = 1'b0; md_in = {3'b000, m_status, m_rdata}; m_ph = 1'b1; m_cnt = 0;
        end else m_cnt++;
      end
    end else begin
      if (mode == 2'd2) begin
        if (m_cnt >= m_rel_dly) begin
          ready = 1'b1; md_in = 16'h0000; m_ph = 1'b0; m_cnt = 0;
        end else m_cnt++;
      end
    end
  end

  task automatic set_req0(input logic [15:0] a, input logic [7:0] d,
                          input logic rw, input logic io, input logic slt);
    addr0 = a; wdata0 = d; rw0 = rw; io0 = io; slt0 = slt; req0 = 1'b1;
  endtask

  task automatic set_req1(input logic [15:0] a, input logic [7:0] d,
                          input logic rw, input logic io, input logic slt);
    addr1 = a; wdata1 = d; rw1 = rw; io1 = io; slt1 = slt; req1 = 1'b1;
  endtask

  task automatic wait_mode(input logic [1:0] m, input int budget, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (mode === m) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_ack(input int budget, output int cyc, output logic g0, output logic g1);
    g0 = 1'b0; g1 = 1'b0; cyc = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      cyc++;
      if (ack0 === 1'b1 || ack1 === 1'b1) begin g0 = ack0; g1 = ack1; break; end
    end
  endtask

  task automatic test_reset();
    logic ok, g0, g1, saw_ack;
    int cyc;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({mode, md_oe, md_out} !== {2'd2, 3'd0, 16'h0000}) begin
      errors++;
      $display("FAIL reset_bus: mode=%0d oe=%b md_out=%h, want 2 000 0000", mode, md_oe, md_out);
    end
    checks++;
    if ({ack0, ack1, err, rdata, status} !== 16'h0000) begin
      errors++;
      $display("FAIL reset_regs: ack0=%b ack1=%b err=%b rdata=%h status=%b, want all 0",
               ack0, ack1, err, rdata, status);
    end
    checks++;
    if (state_dbg !== 3'd0) begin
      errors++; $display("FAIL reset_state: got %0d want 0", state_dbg);
    end
    reset_n = 1'b1;
    // abort in the middle of a command phase
    m_cmd_dly = 1000;
    set_req0(16'h1234, 8'h11, 1'b1, 1'b0, 1'b0);
    wait_mode(2'd1, 20, ok);
    checks++;
    if (ok !== 1'b1) begin errors++; $display("FAIL reset_reach_cmd: mode=%0d want 1", mode); end
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
    #1;
    checks++;
    if ({mode, md_oe, state_dbg} !== {2'd2, 3'd0, 3'd0}) begin
      errors++;
      $display("FAIL reset_abort: mode=%0d oe=%b state=%0d, want 2 000 0", mode, md_oe, state_dbg);
    end
    saw_ack = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (ack0 === 1'b1 || ack1 === 1'b1) saw_ack = 1'b1;
    end
    checks++;
    if (saw_ack !== 1'b0) begin errors++; $display("FAIL reset_no_ack: ack seen=1 want 0"); end
    m_cmd_dly = 2;
    reset_n = 1'b1;
    wait_ack(40, cyc, g0, g1);
    checks++;
    if ({g0, g1} !== 2'b10) begin
      errors++; $display("FAIL reset_rerequest: ack0=%b ack1=%b want 1 0", g0, g1);
    end
    req0 = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_read();
    logic ok, g0, g1;
    int cyc;
    m_cmd_dly = 1; m_rel_dly = 2; m_rdata = 8'h3C; m_status = 5'b10100;
    set_req1(16'h0098, 8'hFF, 1'b0, 1'b1, 1'b0);
    wait_mode(2'd0, 5, ok);
    checks++;
    if ({ok, md_out, md_oe} !== {1'b1, 16'h0098, 3'b111}) begin
      errors++; $display("FAIL read_addr: ok=%b md_out=%h oe=%b want 1 0098 111", ok, md_out, md_oe);
    end
    wait_mode(2'd1, 5, ok);
    checks++;
    if ({ok, md_out, md_oe} !== {1'b1, 16'h80FF, 3'b100}) begin
      errors++; $display("FAIL read_cmd: ok=%b md_out=%h oe=%b want 1 80ff 100", ok, md_out, md_oe);
    end
    wait_ack(30, cyc, g0, g1);
    checks++;
    if ({g0, g1} !== 2'b01) begin errors++; $display("FAIL read_ack: ack0=%b ack1=%b want 0 1", g0, g1); end
    checks++;
    if ({rdata, status, err} !== {8'h3C, 5'b10100, 1'b0}) begin
      errors++; $display("FAIL read_data: rdata=%h status=%b err=%b want 3c 10100 0", rdata, status, err);
    end
    req1 = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_write();
    logic g0, g1;
    int cyc;
    m_cmd_dly = 2; m_rel_dly = 1; m_rdata = 8'hEE; m_status = 5'b00011;
    set_req0(16'h4000, 8'hA5, 1'b1, 1'b0, 1'b1);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      checks++;
      if (i < 3) begin
        if ({mode, md_out, md_oe} !== {2'd0, 16'h4000, 3'b111}) begin
          errors++;
          $display("FAIL write_addr%0d: mode=%0d md_out=%h oe=%b want 0 4000 111", i, mode, md_out, md_oe);
        end
      end else begin
        if ({mode, md_out, md_oe} !== {2'd1, 16'h60A5, 3'b101}) begin
          errors++;
          $display("FAIL write_cmd: mode=%0d md_out=%h oe=%b want 1 60a5 101", mode, md_out, md_oe);
        end
      end
    end
    wait_ack(30, cyc, g0, g1);
    checks++;
    if ({g0, g1, err} !== 3'b100) begin
      errors++; $display("FAIL write_ack: ack0=%b ack1=%b err=%b want 1 0 0", g0, g1, err);
    end
    checks++;
    if ({rdata, status} !== {8'h3C, 5'b00011}) begin
      errors++; $display("FAIL write_hold: rdata=%h status=%b want 3c 00011", rdata, status);
    end
    req0 = 1'b0;
    @(negedge clk);
    checks++;
    if ({ack0, mode} !== {1'b0, 2'd2}) begin
      errors++; $display("FAIL write_pulse: ack0=%b mode=%0d want 0 2", ack0, mode);
    end
  endtask

  task automatic test_early_ready();
    logic ok, g0, g1;
    int cyc;
    m_early = 1'b1; m_cmd_dly = 0; m_rel_dly = 1; m_rdata = 8'h5A; m_status = 5'b01010;
    set_req0(16'hC000, 8'h00, 1'b0, 1'b0, 1'b1);
    wait_mode(2'd1, 10, ok);
    checks++;
    if ({ok, state_dbg} !== {1'b1, 3'd2}) begin
      errors++; $display("FAIL early_cmd: ok=%b state=%0d want 1 2", ok, state_dbg);
    end
    @(negedge clk);
    checks++;
    if ({state_dbg, md_oe} !== {3'd3, 3'b000}) begin
      errors++; $display("FAIL early_capt: state=%0d oe=%b want 3 000", state_dbg, md_oe);
    end
    wait_ack(30, cyc, g0, g1);
    checks++;
    if ({g0, g1, rdata, status} !== {2'b10, 8'h5A, 5'b01010}) begin
      errors++;
      $display("FAIL early_data: ack0=%b ack1=%b rdata=%h status=%b want 1 0 5a 01010", g0, g1, rdata, status);
    end
    req0 = 1'b0; m_early = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_req_drop();
    logic g0, g1;
    int cyc;
    m_cmd_dly = 1; m_rel_dly = 1;
    set_req1(16'h2000, 8'h77, 1'b1, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    req1 = 1'b0;
    wait_ack(30, cyc, g0, g1);
    checks++;
    if ({g0, g1} !== 2'b01) begin errors++; $display("FAIL req_drop_ack: ack0=%b ack1=%b want 0 1", g0, g1); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic g0, g1;
    int cyc;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    m_cmd_dly = 0; m_rel_dly = 0;
    set_req0(16'h0100, 8'h01, 1'b1, 1'b0, 1'b0);
    set_req1(16'h0200, 8'h02, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      wait_ack(20, cyc, g0, g1);
      checks++;
      if ({g0, g1} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
        errors++; $display("FAIL arb_order%0d: ack0=%b ack1=%b want grant %0d", i, g0, g1, i % 2);
      end
      if (i > 0) begin
        checks++;
        if (cyc !== 7) begin errors++; $display("FAIL b2b_spacing%0d: got %0d cycles want 7", i, cyc); end
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
    checks++;
    if (state_dbg !== 3'd0) begin errors++; $display("FAIL arb_idle: state=%0d want 0", state_dbg); end
  endtask

`ifdef MSXSEQ_TIMEOUT_EN
  task automatic test_timeout();
    logic ok, g0, g1;
    int cyc;
    m_cmd_dly = 1000;
    set_req0(16'h3000, 8'h33, 1'b1, 1'b0, 1'b0);
    wait_mode(2'd1, 10, ok);
    wait_ack(25, cyc, g0, g1);
    checks++;
    if ({ok, g0, err} !== 3'b111 || cyc > 19) begin
      errors++; $display("FAIL timeout_ack: ack0=%b err=%b after %0d cycles want 1 1 within 19", g0, err, cyc);
    end
    checks++;
    if (rdata !== 8'h00) begin errors++; $display("FAIL timeout_rdata: got %h want 00", rdata); end
    req0 = 1'b0;
    @(negedge clk);
    checks++;
    if ({mode, ack0} !== {2'd2, 1'b0}) begin
      errors++; $display("FAIL timeout_release: mode=%0d ack0=%b want 2 0", mode, ack0);
    end
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    m_cmd_dly = 1;
  endtask
`endif

  initial begin
    reset_n = 1'b0;
    req0 = 1'b0; req1 = 1'b0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    rw0 = 1'b0; rw1 = 1'b0; io0 = 1'b0; io1 = 1'b0; slt0 = 1'b0; slt1 = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    test_read();
    test_write();
    test_early_ready();
    test_req_drop();
    test_back_to_back();
`ifdef MSXSEQ_TIMEOUT_EN
    test_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
